lct_tmb_tx: RTL and testbench

//  Transmit end of the ALCT trigger path. Takes the best/second-best LCT pair from the trigger

---
 rtl/lct_tmb_tx_if.sv | 30 +++
 rtl/lct_tmb_tx.sv | 139 +++++++++++++
 tb/tb_lct_tmb_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lct_tmb_tx_if.sv
// LCT candidate inputs from the trigger core and LCT word outputs toward the TMB.
// master = trigger-core side, slave = lct_tmb_tx.
interface lct_tmb_tx_if #(
    parameter int unsigned BXN_W  = 12,
    parameter int unsigned DEAD_W = 3
);
    logic              hv, lv;
    logic [1:0]        hp, lp;
    logic [6:0]        hnp, lnp;
    logic              hfap, lfap;
    logic              hpatbp, lpatbp;
    logic              bc0;
    logic              trig_stop;
    logic [DEAD_W-1:0] dead_time;
    logic [11:0]       lct0, lct1;
    logic [BXN_W-1:0]  bxn;
    logic              bxn_err;
    logic              key_err;
    logic [15:0]       lct_cnt;

    modport master (
        output hv, lv, hp, lp, hnp, lnp, hfap, lfap, hpatbp, lpatbp, bc0, trig_stop, dead_time,
        input  lct0, lct1, bxn, bxn_err, key_err, lct_cnt
    );

    modport slave (
        input  hv, lv, hp, lp, hnp, lnp, hfap, lfap, hpatbp, lpatbp, bc0, trig_stop, dead_time,
        output lct0, lct1, bxn, bxn_err, key_err, lct_cnt
    );
endinterface

// File: rtl/lct_tmb_tx.sv
// ALCT -> TMB LCT transmitter: validates, orders, dead-time filters and BXN-stamps the
// best/second LCT pair through a two-stage pipeline.
module lct_tmb_tx #(
    parameter int unsigned KEY_MAX = 47,
    parameter int unsigned BXN_W   = 12,
    parameter int unsigned BXN_MAX = 3563,
    parameter int unsigned BXN_OFS = 0,
    parameter int unsigned DEAD_W  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    lct_tmb_tx_if.slave   bus
);
    localparam logic [6:0]       LP_KEY_MAX = 7'(KEY_MAX);
    localparam logic [BXN_W-1:0] LP_BXN_MAX = BXN_W'(BXN_MAX);
    localparam logic [BXN_W-1:0] LP_BXN_OFS = BXN_W'(BXN_OFS);

    typedef enum logic [1:0] {StWaitBc0, StRun, StStop} state_e;

    state_e r_state, w_state_nxt;

    logic [BXN_W-1:0]  r_bxn, w_bxn_nxt;
    logic              r_bxn_err;

    logic [11:0]       r_s1_h, r_s1_l;
    logic [BXN_W-1:0]  r_s1_bxn;
    logic [DEAD_W-1:0] r_s1_dt;

    logic [1:0][DEAD_W-1:0] r_dcnt, w_dcnt_nxt;
    logic [1:0][6:0]        r_dkey, w_dkey_nxt;

    logic [11:0]       r_lct0, r_lct1;
    logic [BXN_W-1:0]  r_bxn_out;
    logic              r_key_err;
    logic [15:0]       r_cnt, w_cnt_nxt;

    logic              w_run;
    logic [6:0]        w_h_key, w_l_key;
    logic              w_h_bad, w_l_bad, w_h_ok, w_l_ok, w_h_sup, w_l_sup, w_h_go, w_l_go;
    logic              w_key_err;
    logic [1:0][11:0]  w_lct;
    logic [1:0]        w_n_tx;
    logic [16:0]       w_sum;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StWaitBc0: if (bus.bc0)        w_state_nxt = StRun;
            StRun:     if (bus.trig_stop)  w_state_nxt = StStop;
            StStop:    if (!bus.trig_stop) w_state_nxt = StRun;
            default:                       w_state_nxt = StWaitBc0;
        endcase
    end

    // bc0 resync wins over the natural increment/wrap
    always_comb begin
        w_bxn_nxt = r_bxn + 1'b1;
        if (bus.bc0)                  w_bxn_nxt = LP_BXN_OFS;
        else if (r_bxn == LP_BXN_MAX) w_bxn_nxt = '0;
    end

    always_comb begin
        w_run   = (r_state == StRun);
        w_h_key = r_s1_h[6:0];
        w_l_key = r_s1_l[6:0];
        w_h_bad = r_s1_h[11] && (w_h_key > LP_KEY_MAX);
        w_l_bad = r_s1_l[11] && (w_l_key > LP_KEY_MAX);
        w_h_ok  = r_s1_h[11] && !w_h_bad;
        w_l_ok  = r_s1_l[11] && !w_l_bad && !(w_h_ok && (w_l_key == w_h_key));
        w_h_sup = ((r_dcnt[0] != '0) && (r_dkey[0] == w_h_key)) ||
                  ((r_dcnt[1] != '0) && (r_dkey[1] == w_h_key));
        w_l_sup = ((r_dcnt[0] != '0) && (r_dkey[0] == w_l_key)) ||
                  ((r_dcnt[1] != '0) && (r_dkey[1] == w_l_key));
        w_h_go  = w_run && w_h_ok && !w_h_sup;
        w_l_go  = w_run && w_l_ok && !w_l_sup;
        w_key_err = w_h_bad || w_l_bad;
        // a lone surviving second candidate is promoted into lct0
        w_lct[0] = w_h_go ? r_s1_h : (w_l_go ? r_s1_l : 12'd0);
        w_lct[1] = (w_h_go && w_l_go) ? r_s1_l : 12'd0;
        w_n_tx   = {1'b0, w_lct[0][11]} + {1'b0, w_lct[1][11]};
        w_sum    = {1'b0, r_cnt} + {15'd0, w_n_tx};
        w_cnt_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    always_comb begin
        w_dcnt_nxt = r_dcnt;
        w_dkey_nxt = r_dkey;
        for (int i = 0; i < 2; i++) begin
            if (w_lct[i][11]) begin
                w_dcnt_nxt[i] = r_s1_dt;
                w_dkey_nxt[i] = w_lct[i][6:0];
            end else if (w_run && (r_dcnt[i] != '0)) begin
                w_dcnt_nxt[i] = r_dcnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StWaitBc0;
            r_bxn     <= '0;
            r_bxn_err <= 1'b0;
            r_s1_h    <= '0;
            r_s1_l    <= '0;
            r_s1_bxn  <= '0;
            r_s1_dt   <= '0;
            r_dcnt    <= '0;
            r_dkey    <= '0;
            r_lct0    <= '0;
            r_lct1    <= '0;
            r_bxn_out <= '0;
            r_key_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bxn     <= w_bxn_nxt;
            r_bxn_err <= r_bxn_err ||
                         (bus.bc0 && (r_state != StWaitBc0) && (r_bxn != LP_BXN_MAX));
            r_s1_h    <= {bus.hv, bus.hp, bus.hfap, bus.hpatbp, bus.hnp};
            r_s1_l    <= {bus.lv, bus.lp, bus.lfap, bus.lpatbp, bus.lnp};
            r_s1_bxn  <= r_bxn;
            r_s1_dt   <= bus.dead_time;
            r_dcnt    <= w_dcnt_nxt;
            r_dkey    <= w_dkey_nxt;
            r_lct0    <= w_lct[0];
            r_lct1    <= w_lct[1];
            r_bxn_out <= r_s1_bxn;
            r_key_err <= w_key_err;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.lct0    = r_lct0;
    assign bus.lct1    = r_lct1;
    assign bus.bxn     = r_bxn_out;
    assign bus.bxn_err = r_bxn_err;
    assign bus.key_err = r_key_err;
    assign bus.lct_cnt = r_cnt;
endmodule

// File: tb/tb_lct_tmb_tx.sv
// Scoreboard bench for lct_tmb_tx: stimulus pushes model predictions, a monitor pops and
// compares them against the outputs after every clock edge.
module tb_lct_tmb_tx;
    localparam int KEY_MAX = 47;
    localparam int BXN_MAX = 3563;
    localparam int BXN_OFS = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lct_tmb_tx_if #(.BXN_W(12), .DEAD_W(3)) bus ();

    lct_tmb_tx #(
        .KEY_MAX (KEY_MAX),
        .BXN_W   (12),
        .BXN_MAX (BXN_MAX),
        .BXN_OFS (BXN_OFS),
        .DEAD_W  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int edge_no;
        int lct0;
        int lct1;
        int bxn;
        int bxn_err;
        int key_err;
        int cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model state: 0 = waiting for bc0, 1 = running, 2 = stopped
    int m_state = 0;
    int m_bxn = 0;
    int m_bxn_err = 0;
    int m_dcnt[2] = '{0, 0};
    int m_dkey[2] = '{0, 0};
    int m_cnt = 0;
    int p_lct0 = 0, p_lct1 = 0, p_bxn = 0, p_kerr = 0;
    int k_edge = 0;
    int stop_lvl = 0;

    task automatic chk(input string name, input int edge_no, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge %0d: got 0x%0h want 0x%0h", name, edge_no, act, exp);
        end
    endtask

    function automatic bit blocked(input int key);
        return (m_dcnt[0] != 0 && key == m_dkey[0]) || (m_dcnt[1] != 0 && key == m_dkey[1]);
    endfunction

    task automatic step(input bit hv, input int hp, input int hnp, input bit hfap,
                        input bit hpatbp, input bit lv, input int lp, input int lnp,
                        input bit lfap, input bit lpatbp, input bit bc0, input bit stop,
                        input int dt);
        exp_t e;
        int   stamp, hword, lword;
        bit   h_ok, l_ok;
        int   sent[$];
        bus.hv = hv;  bus.hp = 2'(hp);  bus.hnp = 7'(hnp);  bus.hfap = hfap;  bus.hpatbp = hpatbp;
        bus.lv = lv;  bus.lp = 2'(lp);  bus.lnp = 7'(lnp);  bus.lfap = lfap;  bus.lpatbp = lpatbp;
        bus.bc0 = bc0;  bus.trig_stop = stop;  bus.dead_time = 3'(dt);

        if (bc0 && m_state != 0 && m_bxn != BXN_MAX) m_bxn_err = 1;
        e.edge_no = k_edge;  e.lct0 = p_lct0;  e.lct1 = p_lct1;  e.bxn = p_bxn;
        e.key_err = p_kerr;  e.cnt = m_cnt;  e.bxn_err = m_bxn_err;
        q.push_back(e);

        stamp = m_bxn;
        m_bxn = bc0 ? BXN_OFS : (m_bxn + 1) % (BXN_MAX + 1);
        if (m_state == 0 && bc0) m_state = 1;
        else if (m_state == 1 && stop) m_state = 2;
        else if (m_state == 2 && !stop) m_state = 1;

        hword = (int'(hv) << 11) | (hp << 9) | (int'(hfap) << 8) | (int'(hpatbp) << 7) | hnp;
        lword = (int'(lv) << 11) | (lp << 9) | (int'(lfap) << 8) | (int'(lpatbp) << 7) | lnp;
        h_ok = hv && hnp <= KEY_MAX;
        l_ok = lv && lnp <= KEY_MAX && !(h_ok && lnp == hnp);
        p_kerr = ((hv && hnp > KEY_MAX) || (lv && lnp > KEY_MAX)) ? 1 : 0;
        if (m_state == 1) begin
            if (h_ok && !blocked(hnp)) sent.push_back(hword);
            if (l_ok && !blocked(lnp)) sent.push_back(lword);
            for (int s = 0; s < 2; s++) begin
                if (s < sent.size()) begin
                    m_dcnt[s] = dt;
                    m_dkey[s] = sent[s] % 128;
                end else if (m_dcnt[s] > 0) begin
                    m_dcnt[s]--;
                end
            end
        end
        p_lct0 = (sent.size() > 0) ? sent[0] : 0;
        p_lct1 = (sent.size() > 1) ? sent[1] : 0;
        p_bxn  = stamp;
        m_cnt  = (m_cnt + sent.size() > 65535) ? 65535 : m_cnt + sent.size();
        k_edge++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int dt);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dt);
    endtask

    task automatic rnd_step(input bit rand_bc0, input int dt);
        int  hk, lk;
        bit  bc0;
        hk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
        lk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
        if ($urandom_range(0, 39) == 0) stop_lvl = 1 - stop_lvl;
        bc0 = rand_bc0 ? ($urandom_range(0, 299) == 0) : (m_bxn == BXN_MAX);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3), hk, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, $urandom_range(0, 3), lk,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bc0, stop_lvl[0], dt);
    endtask

    initial begin
        int e;
        exp_t x;
        e = 0;
        wait (rst_n);
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0 && q[0].edge_no == e) begin
                x = q.pop_front();
                chk("lct0",    e, 32'(bus.lct0),    x.lct0);
                chk("lct1",    e, 32'(bus.lct1),    x.lct1);
                chk("bxn",     e, 32'(bus.bxn),     x.bxn);
                chk("bxn_err", e, 32'(bus.bxn_err), x.bxn_err);
                chk("key_err", e, 32'(bus.key_err), x.key_err);
                chk("lct_cnt", e, 32'(bus.lct_cnt), x.cnt);
            end
            e++;
        end
    end

    initial begin
        int dt;
        int wait_cyc;
        bus.hv = 0;  bus.hp = 0;  bus.hnp = 0;  bus.hfap = 0;  bus.hpatbp = 0;
        bus.lv = 0;  bus.lp = 0;  bus.lnp = 0;  bus.lfap = 0;  bus.lpatbp = 0;
        bus.bc0 = 0; bus.trig_stop = 0; bus.dead_time = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_lct0",    -1, 32'(bus.lct0),    0);
        chk("rst_lct1",    -1, 32'(bus.lct1),    0);
        chk("rst_bxn",     -1, 32'(bus.bxn),     0);
        chk("rst_bxn_err", -1, 32'(bus.bxn_err), 0);
        chk("rst_key_err", -1, 32'(bus.key_err), 0);
        chk("rst_lct_cnt", -1, 32'(bus.lct_cnt), 0);

        // no bc0 yet: LCTs must stay invalid
        for (int i = 0; i < 3; i++) step(1, 2, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 2, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 5, 1, 0, 1, 1, 20, 0, 1, 0, 0, 0);
        idle(2, 0);
        // dead time 3 on repeated key 7
        for (int i = 0; i < 5; i++) step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        idle(4, 3);
        step(0, 0, 0, 0, 0, 1, 2, 12, 1, 1, 0, 0, 0);
        step(1, 3, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 9, 0, 0, 1, 2, 9, 0, 0, 0, 0, 0);
        // trig_stop burst
        for (int i = 0; i < 6; i++) step(1, 2, 20 + i, 0, 0, 1, 1, 30 + i, 0, 0, 0, i >= 2, 0);
        for (int i = 0; i < 3; i++) step(1, 2, 40 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic with correctly-timed bc0, long enough to cover a BXN wrap
        dt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) dt = $urandom_range(0, 7);
            rnd_step(1'b0, dt);
        end
        // explicit out-of-orbit bc0, then random bc0 timing
        stop_lvl = 0;
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2, 0);
        for (int i = 0; i < 600; i++) rnd_step(1'b1, $urandom_range(0, 7));
        idle(3, 0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
